// File: rtl/thee_sig_gen_pkg.sv
// Shared types and helpers for the NCO-based clock generators.
// Holds the sequencer state encoding and the frequency-word clip.
package thee_sig_gen_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } gen_state_e;

  // Limit a frequency word to half the accumulator range (f_out <= f_clk/2).
  function automatic logic [63:0] clip_word(input logic [63:0] word, input int acc_w);
    logic [63:0] lim;
    lim = 64'd1 << (acc_w - 1);
    return (word > lim) ? lim : word;
  endfunction

endpackage

// File: rtl/thee_phase_acc.sv
// Phase accumulator: adds the frequency word each enabled cycle and
// exposes the registered MSB plus the carry/MSB of the pending sum.
module thee_phase_acc #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [ACC_W-1:0] word,
  output logic             msb,
  output logic             carry,
  output logic             sum_msb
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum     = {1'b0, acc} + {1'b0, word};
  assign carry   = sum[ACC_W];
  assign sum_msb = sum[ACC_W-1];
  assign msb     = acc[ACC_W-1];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (adv) begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/thee_nco_clk_gen.sv
// NCO clock generator: square wave from the phase accumulator MSB, with
// wrap-aligned frequency updates and a clean stop at the end of a period.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accumulator held at 0, words load straight into active
// RUN      | accumulating; new words wait in pending until the next wrap
// STOPPING | enable dropped; finish the current period, then go IDLE
module thee_nco_clk_gen
  import thee_sig_gen_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [ACC_W-1:0] cfg_word,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] tick_count
);

  gen_state_e       state, state_next;
  logic [ACC_W-1:0] active_word, active_next;
  logic [ACC_W-1:0] pend_word, pend_word_next;
  logic             pend, pend_next;
  logic             tick_next;
  logic             acc_clr, acc_adv;
  logic             acc_msb, carry, sum_msb;
  logic             cfg_fire;
  logic [ACC_W-1:0] cfg_clip;

  assign cfg_clip  = ACC_W'(clip_word(64'(cfg_word), ACC_W));
  assign cfg_ready = (state == IDLE) || ((state == RUN) && !pend);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign busy      = (state != IDLE);
  assign clk_out   = acc_msb;

  thee_phase_acc #(.ACC_W(ACC_W)) u_phase_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .adv     (acc_adv),
    .word    (active_word),
    .msb     (acc_msb),
    .carry   (carry),
    .sum_msb (sum_msb)
  );

  always_comb begin
    state_next     = state;
    active_next    = active_word;
    pend_word_next = pend_word;
    pend_next      = pend;
    tick_next      = 1'b0;
    acc_clr        = 1'b0;
    acc_adv        = 1'b0;
    case (state)
      IDLE: begin
        acc_clr = 1'b1;
        if (cfg_fire) active_next = cfg_clip;
        if (enable && (active_word != '0)) state_next = RUN;
      end
      RUN: begin
        acc_adv   = 1'b1;
        tick_next = sum_msb && !acc_msb;
        if (carry && pend) begin
          active_next = pend_word;
          pend_next   = 1'b0;
        end
        // cfg_fire implies pend was clear, so it never collides with the apply above
        if (cfg_fire) begin
          pend_word_next = cfg_clip;
          pend_next      = 1'b1;
        end
        if (!enable) state_next = STOPPING;
      end
      STOPPING: begin
        acc_adv = 1'b1;
        if (carry) begin
          state_next = IDLE;
          acc_clr    = 1'b1;
          if (pend) begin
            active_next = pend_word;
            pend_next   = 1'b0;
          end
        end else begin
          tick_next = sum_msb && !acc_msb;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      active_word <= '0;
      pend_word   <= '0;
      pend        <= 1'b0;
      tick        <= 1'b0;
      tick_count  <= '0;
    end else begin
      state       <= state_next;
      active_word <= active_next;
      pend_word   <= pend_word_next;
      pend        <= pend_next;
      tick        <= tick_next;
      if (tick_next) tick_count <= tick_count + 1'b1;
    end
  end

endmodule

// File: doc/thee_nco_clk_gen.md
THEE_NCO_CLK_GEN -- requirements
Module: thee_nco_clk_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 32, phase-accumulator and frequency-word width (min 8).
REQ-002 SHALL have parameter CNT_W, default 16, width of the output-tick counter.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  level request to run the generator.
REQ-006 SHALL have port cfg_word  input  ACC_W  frequency word; f_out = cfg_word * f_clk / 2^ACC_W.
REQ-007 SHALL have port cfg_valid  input  1  cfg_word qualifier.
REQ-008 SHALL have port cfg_ready  output  1  config accept; transfer when cfg_valid && cfg_ready.
REQ-009 SHALL have port clk_out  output  1  generated square wave, equal to accumulator MSB, registered.
REQ-010 SHALL have port tick  output  1  one-cycle pulse in the cycle clk_out is first high.
REQ-011 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-012 SHALL have port tick_count  output  CNT_W  count of ticks since reset, wraps modulo 2^CNT_W.

Function
REQ-013 SHALL implement states IDLE, RUN, STOPPING.
REQ-014 SHALL hold an active word register and a pending word register with pending flag.
REQ-015 SHALL clip accepted cfg_word above 2^(ACC_W-1) to 2^(ACC_W-1) (max f_out = f_clk/2).
REQ-016 In IDLE, cfg_ready SHALL be 1 and an accepted word SHALL load the active register on the next edge.
REQ-017 IDLE -> RUN SHALL occur when enable=1 and active word != 0; accumulator SHALL be 0 on entry.
REQ-018 enable=1 with active word 0 SHALL leave the block in IDLE, busy=0.
REQ-019 In RUN and STOPPING, the accumulator SHALL add the active word every cycle, modulo 2^ACC_W.
REQ-020 A wrap is the cycle where the addition carries out; clk_out is then 0 after the edge.
REQ-021 tick SHALL be registered: high for exactly one cycle when accumulator MSB goes 0->1.
REQ-022 In RUN, cfg_ready SHALL equal not pending; an accepted word SHALL set pending.
REQ-023 Pending word SHALL become active at the next wrap, clearing pending; no partial periods.
REQ-024 Acceptance in the same cycle as a wrap SHALL apply at the following wrap.
REQ-025 In STOPPING and any state with pending=1, cfg_ready SHALL be 0.
REQ-026 RUN -> STOPPING SHALL occur when enable=0; the current period SHALL complete.
REQ-027 STOPPING -> IDLE SHALL occur at the next wrap; accumulator cleared, clk_out=0, pending word applied if set.
REQ-028 enable reasserted during STOPPING SHALL be ignored until IDLE is reached.
REQ-029 tick_count SHALL increment on every tick and wrap from all-ones to 0.

Reset
REQ-030 On rst: state IDLE, accumulator 0, active and pending words 0, pending 0.
REQ-031 On rst: clk_out 0, tick 0, busy 0, tick_count 0, cfg_ready 1 on the first cycle after reset.
REQ-032 rst mid-RUN SHALL override all else; clk_out SHALL be low the next cycle with no tick.

Structure
REQ-033 State enum and clip helper SHALL live in shared package thee_sig_gen_pkg.
REQ-034 Phase accumulator with carry-out SHALL be sub-module thee_phase_acc; the FSM and config handling stay in the top.

Verification
REQ-035 ACC_W=32, word 0x4000_0000, enable=1 -> clk_out period 4 clk, 2 high/2 low, tick every 4 cycles.
REQ-036 Running at 0x4000_0000, load 0x2000_0000 mid-period -> cfg_ready=0 until wrap; then period 8; no short pulse.
REQ-037 Word 0x8000_0001 -> clipped to 0x8000_0000; clk_out toggles every cycle; tick every 2 cycles.
REQ-038 Word 0x4000_0000, drop enable while clk_out=1 -> high phase completes; busy falls at wrap; clk_out stays 0.
REQ-039 rst asserted mid-RUN -> all outputs at reset values next cycle; a word of 0 with enable=1 then keeps busy=0.
REQ-040 Run 65537 ticks with CNT_W=16 -> tick_count wraps to 1.
